life_sequencer: RTL and testbench

//  Controller between the 4x4 life array and its inputs. Issues generation-advance (run) pulses

---
 rtl/life_sequencer_if.sv | 37 +++
 rtl/life_sequencer.sv | 146 ++++++++++++++
 tb/tb_life_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/life_sequencer_if.sv
// rtl/life_sequencer_if.sv - control, seed-load, user-edit and array write-port bundle for life_sequencer
interface life_sequencer_if #(
  parameter int GEN_W = 16
) ();
  logic             frame;
  logic             start;
  logic             stop;
  logic             step;
  logic             load_req;
  logic [15:0]      load_pattern;
  logic             user_req;
  logic [1:0]       user_row;
  logic [1:0]       user_col;
  logic             user_val;
  logic [1:0]       row;
  logic [1:0]       col;
  logic             val;
  logic             write_enb;
  logic             run;
  logic             user_ack;
  logic             running;
  logic             load_busy;
  logic [GEN_W-1:0] gen_count;

  // master: the sequencer, which owns the array write port and run strobe
  modport master (
    input  frame, start, stop, step, load_req, load_pattern,
           user_req, user_row, user_col, user_val,
    output row, col, val, write_enb, run, user_ack, running, load_busy, gen_count
  );

  modport slave (
    output frame, start, stop, step, load_req, load_pattern,
           user_req, user_row, user_col, user_val,
    input  row, col, val, write_enb, run, user_ack, running, load_busy, gen_count
  );
endinterface

// File: rtl/life_sequencer.sv
// rtl/life_sequencer.sv - 4x4 life array run pacing, seed load and write-port arbitration
// Optional auto-stop at GEN_LIMIT generations: define LIFE_SEQ_GEN_LIMIT_EN.
module life_sequencer #(
  parameter int FRAMES_PER_GEN = 30,
  parameter int GEN_W          = 16,
  parameter int GEN_LIMIT      = 100
) (
  input  logic          clk,
  input  logic          reset,
  life_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, LOAD} state_t;

  localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_GEN - 1);

  state_t           state, state_n;
  logic [3:0]       idx, idx_n;
  logic [15:0]      pattern, pattern_n;
  logic [7:0]       frame_cnt, frame_cnt_n;
  logic [GEN_W-1:0] gen_q, gen_n, gen_inc;
  logic [1:0]       row_q, row_n, col_q, col_n;
  logic             val_q, val_n;
  logic             we_q, we_n, run_q, run_n, ack_q, ack_n;
  logic             running_q, running_n, busy_q, busy_n;

`ifndef LIFE_SEQ_GEN_LIMIT_EN
  localparam int gen_limit_unused = GEN_LIMIT;
`endif

  assign gen_inc = gen_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      pattern   <= '0;
      frame_cnt <= '0;
      gen_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      val_q     <= 1'b0;
      we_q      <= 1'b0;
      run_q     <= 1'b0;
      ack_q     <= 1'b0;
      running_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      pattern   <= pattern_n;
      frame_cnt <= frame_cnt_n;
      gen_q     <= gen_n;
      row_q     <= row_n;
      col_q     <= col_n;
      val_q     <= val_n;
      we_q      <= we_n;
      run_q     <= run_n;
      ack_q     <= ack_n;
      running_q <= running_n;
      busy_q    <= busy_n;
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    pattern_n   = pattern;
    frame_cnt_n = frame_cnt;
    gen_n       = gen_q;
    row_n       = row_q;
    col_n       = col_q;
    val_n       = val_q;
    we_n        = 1'b0;
    run_n       = 1'b0;
    ack_n       = 1'b0;
    busy_n      = 1'b0;
    case (state)
      LOAD: begin
        we_n   = 1'b1;
        busy_n = 1'b1;
        row_n  = idx[3:2];
        col_n  = idx[1:0];
        val_n  = pattern[idx];
        idx_n  = idx + 4'd1;
        if (idx == 4'd15) begin
          state_n     = IDLE;
          gen_n       = '0;
          frame_cnt_n = '0;
        end
      end
      default: begin
        if (bus.load_req) begin
          // cell 0 is written on the way into LOAD so the first write lands one cycle after the request
          state_n   = LOAD;
          pattern_n = bus.load_pattern;
          we_n      = 1'b1;
          busy_n    = 1'b1;
          row_n     = 2'd0;
          col_n     = 2'd0;
          val_n     = bus.load_pattern[0];
          idx_n     = 4'd1;
        end else begin
          if (state == IDLE) begin
            if (bus.start && !bus.stop) state_n = RUN;
            if (bus.step) begin
              run_n = 1'b1;
              gen_n = gen_inc;
            end
          end else if (bus.stop) begin
            state_n = IDLE;
          end else if (bus.frame) begin
            if (frame_cnt == LAST_FRAME) begin
              frame_cnt_n = '0;
              run_n       = 1'b1;
              gen_n       = gen_inc;
`ifdef LIFE_SEQ_GEN_LIMIT_EN
              if (gen_inc == GEN_W'(GEN_LIMIT)) state_n = IDLE;
`endif
            end else begin
              frame_cnt_n = frame_cnt + 8'd1;
            end
          end
          // previous-cycle ack forces one idle cycle before serving a still-high request
          if (!run_n && bus.user_req && !ack_q) begin
            we_n  = 1'b1;
            ack_n = 1'b1;
            row_n = bus.user_row;
            col_n = bus.user_col;
            val_n = bus.user_val;
          end
        end
      end
    endcase
    running_n = (state_n == RUN);
  end

  assign bus.row       = row_q;
  assign bus.col       = col_q;
  assign bus.val       = val_q;
  assign bus.write_enb = we_q;
  assign bus.run       = run_q;
  assign bus.user_ack  = ack_q;
  assign bus.running   = running_q;
  assign bus.load_busy = busy_q;
  assign bus.gen_count = gen_q;
endmodule

// File: tb/tb_life_sequencer.sv
// tb/tb_life_sequencer.sv - table-driven and scoreboard bench for life_sequencer
module tb_life_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

`ifdef LIFE_SEQ_GEN_LIMIT_EN
  localparam bit LIMIT_ON = 1'b1;
`else
  localparam bit LIMIT_ON = 1'b0;
`endif

  life_sequencer_if #(.GEN_W(16)) bus ();

  life_sequencer #(.FRAMES_PER_GEN(3), .GEN_W(16), .GEN_LIMIT(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic       kind;   // 1 = run pulse, 0 = array write
    logic [1:0] r;
    logic [1:0] c;
    logic       v;
    logic       ack;
  } ev_t;

  typedef struct {
    int          op;    // 0 user edit, 1 load, 2 step
    logic [15:0] pat;
    logic [1:0]  r;
    logic [1:0]  c;
    logic        v;
  } vec_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  exp_gen = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [1:0] r, input logic [1:0] c, input logic v, input logic ack);
    ev_t e;
    e.kind = 1'b0; e.r = r; e.c = c; e.v = v; e.ack = ack;
    exp_q.push_back(e);
  endtask

  task automatic push_run();
    ev_t e;
    e = '0;
    e.kind = 1'b1;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("no_overlap", bus.run & bus.write_enb, 0);
      if (bus.run || bus.write_enb) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event run=%0d write_enb=%0d row=%0d col=%0d", bus.run, bus.write_enb, bus.row, bus.col);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("event_kind", bus.run, e.kind);
          if (!e.kind) begin
            chk("wr_row", bus.row, e.r);
            chk("wr_col", bus.col, e.c);
            chk("wr_val", bus.val, e.v);
            chk("wr_ack", bus.user_ack, e.ack);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    bit   got;
    tbl[0] = '{2, 16'h0000, 2'd0, 2'd0, 1'b0};
    tbl[1] = '{2, 16'h0000, 2'd0, 2'd0, 1'b0};
    tbl[2] = '{1, 16'h8001, 2'd0, 2'd0, 1'b0};
    tbl[3] = '{0, 16'h0000, 2'd1, 2'd2, 1'b1};
    tbl[4] = '{0, 16'h0000, 2'd3, 2'd0, 1'b0};
    tbl[5] = '{2, 16'h0000, 2'd0, 2'd0, 1'b0};
    tbl[6] = '{1, 16'hA5C3, 2'd0, 2'd0, 1'b0};
    tbl[7] = '{0, 16'h0000, 2'd0, 2'd3, 1'b1};
    tbl[8] = '{0, 16'h0000, 2'd3, 2'd3, 1'b1};

    bus.frame = 0; bus.start = 0; bus.stop = 0; bus.step = 0;
    bus.load_req = 0; bus.load_pattern = '0;
    bus.user_req = 0; bus.user_row = 0; bus.user_col = 0; bus.user_val = 0;

    repeat (3) tick();
    chk("rst_write_enb", bus.write_enb, 0);
    chk("rst_run", bus.run, 0);
    chk("rst_running", bus.running, 0);
    chk("rst_load_busy", bus.load_busy, 0);
    chk("rst_gen_count", bus.gen_count, 0);
    chk("rst_rowcolval", {bus.row, bus.col, bus.val}, 0);
    reset = 1'b0;
    tick();

    // table: steps, loads and single-cell edits from IDLE
    for (int i = 0; i < 9; i++) begin
      case (tbl[i].op)
        2: begin
          bus.step = 1; push_run(); exp_gen++;
          tick();
          bus.step = 0;
          chk("step_run", bus.run, 1);
          tick();
        end
        1: begin
          bus.load_req = 1; bus.load_pattern = tbl[i].pat;
          for (int k = 0; k < 16; k++) push_wr(k[3:2], k[1:0], tbl[i].pat[k], 1'b0);
          tick();
          bus.load_req = 0;
          chk("load_busy_first", bus.load_busy, 1);
          repeat (15) tick();
          chk("load_busy_last", bus.load_busy, 1);
          tick();
          exp_gen = 0;
          chk("load_busy_done", bus.load_busy, 0);
          chk("load_we_done", bus.write_enb, 0);
        end
        default: begin
          bus.user_row = tbl[i].r; bus.user_col = tbl[i].c; bus.user_val = tbl[i].v;
          bus.user_req = 1;
          push_wr(tbl[i].r, tbl[i].c, tbl[i].v, 1'b1);
          got = 0;
          for (int k = 0; k < 8 && !got; k++) begin
            tick();
            got = bus.user_ack;
          end
          chk("user_ack_seen", got, 1);
          bus.user_req = 0;
          tick();
        end
      endcase
      chk("tbl_gen_count", bus.gen_count, exp_gen);
    end

    // reset in the middle of a load, after five writes
    bus.load_req = 1; bus.load_pattern = 16'hFFFF;
    for (int k = 0; k < 16; k++) push_wr(k[3:2], k[1:0], 1'b1, 1'b0);
    tick();
    bus.load_req = 0;
    repeat (4) tick();
    @(negedge clk);
    #1;
    chk("midload_queue", exp_q.size(), 11);
    reset = 1'b1;
    #1;
    exp_q.delete();
    exp_gen = 0;
    chk("midload_we", bus.write_enb, 0);
    chk("midload_busy", bus.load_busy, 0);
    chk("midload_rowcolval", {bus.row, bus.col, bus.val}, 0);
    tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("midload_idle", bus.load_busy, 0);

    // frame pacing with FRAMES_PER_GEN=3
    bus.start = 1; tick(); bus.start = 0;
    chk("start_running", bus.running, 1);
    for (int f = 1; f <= 7; f++) begin
      bus.frame = 1;
      if (f % 3 == 0) begin push_run(); exp_gen++; end
      tick();
      bus.frame = 0;
      chk("pace_run", bus.run, (f % 3 == 0));
      repeat (2) tick();
    end
    chk("pace_gen", bus.gen_count, exp_gen);

    // step ignored in RUN; stop; start&stop in IDLE
    bus.step = 1; tick(); bus.step = 0;
    chk("step_in_run", bus.run, 0);
    chk("step_in_run_gen", bus.gen_count, exp_gen);
    bus.stop = 1; tick(); bus.stop = 0;
    chk("stop_running", bus.running, 0);
    bus.start = 1; bus.stop = 1; tick(); bus.start = 0; bus.stop = 0;
    chk("startstop_running", bus.running, 0);
    tick();
    chk("startstop_hold", bus.running, 0);

    // user edit colliding with a run pulse (frame counter is at 1 here)
    bus.start = 1; tick(); bus.start = 0;
    bus.frame = 1; tick(); bus.frame = 0;
    chk("collide_pre_run", bus.run, 0);
    tick();
    bus.frame = 1; bus.user_req = 1;
    bus.user_row = 2'd2; bus.user_col = 2'd1; bus.user_val = 1'b1;
    push_run(); push_wr(2'd2, 2'd1, 1'b1, 1'b1); exp_gen++;
    tick();
    bus.frame = 0;
    chk("collide_run", bus.run, 1);
    chk("collide_we_first", bus.write_enb, 0);
    tick();
    chk("collide_we_next", bus.write_enb, 1);
    chk("collide_ack_next", bus.user_ack, 1);
    bus.user_req = 0;
    tick();
    bus.stop = 1; tick(); bus.stop = 0;
    chk("collide_gen", bus.gen_count, exp_gen);

    // held user_req is served every other cycle
    bus.user_row = 2'd1; bus.user_col = 2'd1; bus.user_val = 1'b0; bus.user_req = 1;
    push_wr(2'd1, 2'd1, 1'b0, 1'b1); push_wr(2'd1, 2'd1, 1'b0, 1'b1);
    tick(); chk("spacing_ack0", bus.user_ack, 1);
    tick(); chk("spacing_gap", bus.user_ack, 0);
    tick(); chk("spacing_ack1", bus.user_ack, 1);
    bus.user_req = 0;
    tick();

    // generation limit (GEN_LIMIT=2) or free-running, depending on build
    reset = 1'b1; tick(); reset = 1'b0; exp_gen = 0;
    bus.start = 1; tick(); bus.start = 0;
    for (int f = 1; f <= 9; f++) begin
      bus.frame = 1;
      if ((f % 3 == 0) && (!LIMIT_ON || f <= 6)) begin push_run(); exp_gen++; end
      tick();
      bus.frame = 0;
      chk("limit_run", bus.run, ((f % 3 == 0) && (!LIMIT_ON || f <= 6)));
      if (f == 6) chk("limit_running", bus.running, !LIMIT_ON);
      repeat (2) tick();
    end
    chk("limit_gen", bus.gen_count, exp_gen);
    bus.stop = 1; tick(); bus.stop = 0;

    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
